ntsc_timing_sequencer: RTL
==========================

# ntsc_timing_sequencer

Generates the line/field timing that drives the NTSC composite generator: the free-running 4-bit subcarrier phase, the sync, burst and blank controls, and a pixel-request strobe with X/Y coordinates. Upstream pixel and colour-space pipelines use the strobe and coordinates so their Y/I/Q outputs arrive aligned with the active window. The output is a 262-line progressive field at 16 phase clocks per subcarrier cycle (phaseClock = 57.272727 MHz).

## Interface
- LINE_CLOCKS, 3640, phase clocks per line (227.5 subcarrier cycles)
- HSYNC_CLOCKS, 269, horizontal sync width (4.7 µs)
- BURST_START, 304, first clock of burst
- BURST_CLOCKS, 144, burst length (9 cycles)
- ACTIVE_START, 624, first unblanked clock
- PIXELS, 256, pixels per line
- PIXEL_DIV, 11, phase clocks per pixel
- PIXEL_LEAD, 4, clocks that pixelRequest leads the matching unblanked clock
- FIELD_LINES, 262, lines per field
- VSYNC_LINES, 3, broad-sync lines starting at line 0 (used when the macro is absent)
- ACTIVE_FIRST_LINE, 21, first picture line
- ACTIVE_LINES, 240, number of picture lines
- phaseClock  in  1  phase clock
- reset  in  1  synchronous, active-high
- subcarrierPhase  out  4  subcarrier phase, 0..15
- sync  out  1  sync level request
- burst  out  1  colour burst request
- blank  out  1  blank level request
- pixelRequest  out  1  one-clock strobe: supply next pixel
- pixelX  out  9  pixel index of the current/last request, 0..PIXELS-1
- pixelY  out  8  picture line index, 0..ACTIVE_LINES-1
- frameStart  out  1  one-clock pulse at line 0, h 0

## Operation
- Counters: hCount 0..LINE_CLOCKS-1, which wraps and increments vCount; vCount 0..FIELD_LINES-1, which wraps to 0. phaseCount increments every clock mod 16 and never resets on line or field wrap.
  - 3640 mod 16 = 8, so the burst phase alternates 180° line to line.
  - 262×3640 mod 16 = 0, so every field starts at phase 0.
- Line classes, decoded from vCount:
  - VSYNC: vCount < VSYNC_LINES.
  - PICTURE: ACTIVE_FIRST_LINE ≤ vCount < ACTIVE_FIRST_LINE+ACTIVE_LINES.
  - BLANKLINE: all other lines.
- sync:
  - Normal lines: sync = (h < HSYNC_CLOCKS).
  - VSYNC lines: sync = (h < LINE_CLOCKS−HSYNC_CLOCKS), i.e. inverted serration.
- burst: BURST_START ≤ h < BURST_START+BURST_CLOCKS on non-VSYNC lines, including BLANKLINE. Never asserted on VSYNC lines.
- blank: deasserted only on PICTURE lines for ACTIVE_START ≤ h < ACTIVE_END, where ACTIVE_END = ACTIVE_START+PIXELS×PIXEL_DIV. Asserted everywhere else.
- Priority: sync dominates burst, and burst dominates blank.
- Pixel strobe:
  - On PICTURE lines, pixelRequest pulses at h = ACTIVE_START−PIXEL_LEAD+n×PIXEL_DIV for n = 0..PIXELS−1.
  - pixelX = n updates with the strobe.
  - pixelX returns to 0 on the first clock of each line.
- pixelY = vCount−ACTIVE_FIRST_LINE on PICTURE lines. It holds 0 on other lines.
- Elaboration-time checks (fatal $error):
  - ACTIVE_END ≤ LINE_CLOCKS−86 (front porch).
  - PIXEL_LEAD < ACTIVE_START−BURST_START−BURST_CLOCKS.
  - ACTIVE_FIRST_LINE+ACTIVE_LINES ≤ FIELD_LINES.

## Timing
- Reset values, held while reset is high:
  - Counters and subcarrierPhase: 0.
  - sync = 0, burst = 0, blank = 1, pixelRequest = 0, frameStart = 0.
  - pixelX = 0, pixelY = 0.
- Reset asserted mid-line aborts immediately. On the next edge all outputs take their reset values, with no partial sync pulse completion.
- All outputs are registered decodes of the counter position.
  - On the k-th edge after reset falls (k ≥ 1), outputs reflect position p = k−1: h = p mod LINE_CLOCKS, phase = p mod 16.
  - The first edge after reset: sync = 1, blank = 1, frameStart = 1, subcarrierPhase = 0.
- subcarrierPhase and the sync/burst/blank controls update on the same edge, with no skew between them.
- Line wrap and field wrap occur on the same edge when h = LINE_CLOCKS−1 and v = FIELD_LINES−1. The next output reflects (0,0) with frameStart = 1.

## Configuration
- NTSC_EQUALIZING_PULSES_EN defined: the vertical interval is 9 lines and VSYNC_LINES is ignored.
  - Lines 0–2 and 6–8 are equalizing lines: sync for h < 134 and for 1820 ≤ h < 1954.
  - Lines 3–5 are broad lines: sync except for 1551 ≤ h < 1820 and h ≥ 3371.
  - Burst is suppressed on lines 0–8.
- Not defined: VSYNC_LINES inverted-serration lines only, as in Operation.

## Test plan
- Reset, then 10 clocks → first edge: sync = 1, blank = 1, frameStart = 1, subcarrierPhase = 0; subcarrierPhase = 9 on edge 10.
- Run to line 30 → sync high for exactly 269 clocks; burst high for 144 clocks from h = 304; subcarrierPhase at burst start differs by 8 between line 30 and line 31.
- Line 21 → 256 pixelRequest pulses, the first at h = 620 and spaced 11 apart, with pixelX 0..255; blank low for exactly h 624..3439; pixelY = 0.
- One full field (953,680 clocks) → frameStart pulses exactly once per field; subcarrierPhase = 0 at each frameStart; no pixelRequest on lines 0–20 or 261.
- Assert reset for 1 clock at line 21, h = 2000 → next edge: all outputs at reset values; the following edge restarts at (0,0) with frameStart = 1.
- With NTSC_EQUALIZING_PULSES_EN defined → line 0: sync pulses at h 0–133 and 1820–1953; line 4: sync low only over h 1551–1819 and 3371–3639; no burst on lines 0–8; burst present on line 9.

Source files
------------

// File: rtl/ntsc_timing_sequencer.sv
// NTSC line/field timing: subcarrier phase, sync/burst/blank controls and pixel-request strobe.
// Define NTSC_EQUALIZING_PULSES_EN for a 9-line vertical interval with equalizing and broad pulses.
module ntsc_timing_sequencer #(
    parameter int LINE_CLOCKS       = 3640,
    parameter int HSYNC_CLOCKS      = 269,
    parameter int BURST_START       = 304,
    parameter int BURST_CLOCKS      = 144,
    parameter int ACTIVE_START      = 624,
    parameter int PIXELS            = 256,
    parameter int PIXEL_DIV         = 11,
    parameter int PIXEL_LEAD        = 4,
    parameter int FIELD_LINES       = 262,
    parameter int VSYNC_LINES       = 3,
    parameter int ACTIVE_FIRST_LINE = 21,
    parameter int ACTIVE_LINES      = 240
) (
    input  logic       phaseClock,
    input  logic       reset,
    output logic [3:0] subcarrierPhase,
    output logic       sync,
    output logic       burst,
    output logic       blank,
    output logic       pixelRequest,
    output logic [8:0] pixelX,
    output logic [7:0] pixelY,
    output logic       frameStart
);
    localparam int ACTIVE_END = ACTIVE_START + PIXELS * PIXEL_DIV;
    localparam int LEAD_START = ACTIVE_START - PIXEL_LEAD;
    localparam int H_W        = $clog2(LINE_CLOCKS);
    localparam int V_W        = $clog2(FIELD_LINES);
    localparam int D_W        = $clog2(PIXEL_DIV + 1);
`ifdef NTSC_EQUALIZING_PULSES_EN
    localparam int VSYNC_END  = 9;
    localparam int HALF_LINE  = LINE_CLOCKS / 2;
    localparam int EQ_CLOCKS  = HSYNC_CLOCKS / 2;
`else
    localparam int VSYNC_END  = VSYNC_LINES;
`endif

    localparam logic [H_W-1:0] H_LAST = H_W'(LINE_CLOCKS - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(FIELD_LINES - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(PIXEL_DIV - 1);

    if (ACTIVE_END > LINE_CLOCKS - 86) begin : g_front_porch_check
        $error("active window leaves less than 86 clocks of front porch");
    end
    if (PIXEL_LEAD >= ACTIVE_START - BURST_START - BURST_CLOCKS) begin : g_lead_check
        $error("PIXEL_LEAD reaches back into the burst");
    end
    if (ACTIVE_FIRST_LINE + ACTIVE_LINES > FIELD_LINES) begin : g_lines_check
        $error("picture lines exceed the field");
    end

    typedef enum logic [1:0] {LINE_VSYNC, LINE_PICTURE, LINE_BLANK} line_class_t;

    logic [H_W-1:0] hCount;
    logic [V_W-1:0] vCount;
    logic [3:0]     phaseCount;
    logic           pix_run;
    logic [D_W-1:0] pix_div;
    logic [8:0]     pix_next;

    line_class_t line_class;
    int          h;
    int          v;
    logic        sync_d;
    logic        burst_d;
    logic        blank_d;
    logic        lead_hit;
    logic        strobe_d;
    logic [8:0]  strobe_x;
    logic [7:0]  pixel_y_d;
    logic        frame_d;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        h          = int'(hCount);
        v          = int'(vCount);
        line_class = LINE_BLANK;
        if (v < VSYNC_END)
            line_class = LINE_VSYNC;
        else if (v >= ACTIVE_FIRST_LINE && v < ACTIVE_FIRST_LINE + ACTIVE_LINES)
            line_class = LINE_PICTURE;

        sync_d = (h < HSYNC_CLOCKS);
        if (line_class == LINE_VSYNC) begin
`ifdef NTSC_EQUALIZING_PULSES_EN
            // Lines 3..5 are broad pulses; the lines either side carry half-width equalizing pulses.
            if (v >= 3 && v < 6)
                sync_d = !((h >= HALF_LINE - HSYNC_CLOCKS && h < HALF_LINE) ||
                           h >= LINE_CLOCKS - HSYNC_CLOCKS);
            else
                sync_d = (h < EQ_CLOCKS) || (h >= HALF_LINE && h < HALF_LINE + EQ_CLOCKS);
`else
            sync_d = (h < LINE_CLOCKS - HSYNC_CLOCKS);
`endif
        end

        burst_d = (line_class != LINE_VSYNC) && !sync_d &&
                  (h >= BURST_START) && (h < BURST_START + BURST_CLOCKS);
        blank_d = sync_d || burst_d ||
                  !(line_class == LINE_PICTURE && h >= ACTIVE_START && h < ACTIVE_END);

        lead_hit  = (line_class == LINE_PICTURE) && (h == LEAD_START);
        strobe_d  = lead_hit || (pix_run && pix_div == D_LAST);
        strobe_x  = lead_hit ? 9'd0 : pix_next;
        pixel_y_d = (line_class == LINE_PICTURE) ? 8'(v - ACTIVE_FIRST_LINE) : 8'd0;
        frame_d   = (h == 0) && (v == 0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge phaseClock) begin
        if (reset) begin
            hCount          <= '0;
            vCount          <= '0;
            phaseCount      <= '0;
            pix_run         <= 1'b0;
            pix_div         <= '0;
            pix_next        <= '0;
            subcarrierPhase <= '0;
            sync            <= 1'b0;
            burst           <= 1'b0;
            blank           <= 1'b1;
            pixelRequest    <= 1'b0;
            pixelX          <= '0;
            pixelY          <= '0;
            frameStart      <= 1'b0;
        end else begin
            // Phase free-runs across line and field wraps; the line length sets the burst alternation.
            phaseCount <= phaseCount + 4'd1;
            if (hCount == H_LAST) begin
                hCount <= '0;
                vCount <= (vCount == V_LAST) ? '0 : vCount + V_W'(1);
            end else begin
                hCount <= hCount + H_W'(1);
            end

            if (lead_hit) begin
                pix_run  <= 1'b1;
                pix_div  <= '0;
                pix_next <= 9'd1;
            end else if (pix_run) begin
                if (pix_div == D_LAST) begin
                    pix_div  <= '0;
                    pix_next <= pix_next + 9'd1;
                    if (pix_next == 9'(PIXELS - 1))
                        pix_run <= 1'b0;
                end else begin
                    pix_div <= pix_div + D_W'(1);
                end
            end

            subcarrierPhase <= phaseCount;
            sync            <= sync_d;
            burst           <= burst_d;
            blank           <= blank_d;
            pixelRequest    <= strobe_d;
            pixelY          <= pixel_y_d;
            frameStart      <= frame_d;
            if (h == 0)
                pixelX <= '0;
            else if (strobe_d)
                pixelX <= strobe_x;
        end
    end
endmodule
